change_dispenser: RTL and testbench
===================================

# change_dispenser

Coin-return transmitter of the vending machine. It is the output-side counterpart to the coin-input FSM, which senses in50/in100 and drives give_coffee. The FSM hands this block a refund or change amount in 50-units. The block drives pulses to the 100-coin and 50-coin hoppers, one coin at a time, waiting for each hopper acknowledge before the next coin, and reports completion.

## Interface
- AMT_W, 4: width of amount field, in 50-units (max refund 15×50)
- PULSE_LEN, 2: cycles a hopper drive pulse is held high (≥1)
- GAP_LEN, 2: idle cycles between coins (≥1)
- TIMEOUT, 16: WAIT_ACK cycles before error (only with CHANGE_TIMEOUT_EN)

Reset is synchronous and active-high on `reset`; single clock `clk`.

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  refund request strobe
- req_amount  in  AMT_W  amount to return, in 50-units
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- hopper100_empty  in  1  100-hopper empty; pay with 50s instead
- hopper_ack  in  1  hopper reports one coin dropped
- out100  out  1  drive pulse to 100-hopper
- out50  out  1  drive pulse to 50-hopper
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when refund completes
- error  out  1  sticky hopper timeout flag (tied 0 without CHANGE_TIMEOUT_EN)

## Operation
- States: IDLE, SELECT, PULSE, WAIT_ACK, GAP, DONE, ERROR (ERROR only with macro).
- Reset values: state=IDLE, remaining=0, out100=out50=done=error=busy=0, req_ready=1.
- IDLE, on accept: latch req_amount into `remaining`.
  - amount≠0 → SELECT.
  - amount=0 → DONE directly, no coins.
- SELECT (1 cycle): choose the coin.
  - remaining≥2 and !hopper100_empty → coin=100.
  - Otherwise coin=50.
  - hopper100_empty is sampled in SELECT only. → PULSE.
- PULSE: assert out100 or out50 (never both) for exactly PULSE_LEN cycles → WAIT_ACK.
  - hopper_ack during PULSE is ignored.
- WAIT_ACK: outputs low. On hopper_ack=1, decrement remaining by 2 (coin 100) or 1 (coin 50) → GAP.
- GAP: GAP_LEN cycles, then DONE if remaining=0, else SELECT.
- DONE (1 cycle): done=1 → IDLE.
- Requests while busy are not accepted (req_ready=0) and are not queued.
- Arithmetic: remaining is AMT_W bits unsigned. A 100 coin is only chosen when remaining≥2, so no underflow.
- Reset mid-operation: next edge returns to IDLE with all outputs low. The unpaid remainder is discarded.

## Timing
- Accept at edge 0 (amount=1, hopper_ack already high):
  - SELECT in cycle 1.
  - out50 high in cycles 2–3.
  - WAIT_ACK in cycle 4, ack sampled there.
  - GAP in cycles 5–6.
  - DONE (done=1) in cycle 7.
  - IDLE / req_ready=1 in cycle 8.
- Per coin with immediate ack: 1 + PULSE_LEN + 1 + GAP_LEN = 6 cycles at defaults.
- amount=0: done=1 in cycle 1, req_ready=1 in cycle 2.
- All outputs are registered (state-decoded from registers); no combinational input→output paths.

## Configuration
- CHANGE_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_ACK.
  - If TIMEOUT consecutive cycles pass with no ack → ERROR.
  - In ERROR: error=1, busy=1, req_ready=0, out*=0. The block stays in ERROR until reset.
- CHANGE_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely, error is tied 0, and there is no ERROR state or counter logic.

## Structure
- Shared package vm_pkg holds:
  - the state enum (chg_state_t)
  - the coin-select enum (COIN_50, COIN_100)
  - COIN_UNIT=50 constant, which is also used by the coin-input FSM
- Sub-module `chg_timer`: one loadable down-counter with a zero flag. It is reused for the PULSE_LEN, GAP_LEN and TIMEOUT intervals.

## Test plan
- amount=3, hopper100_empty=0, ack one cycle after each pulse → one out100 pulse then one out50 pulse, each 2 cycles wide; single done pulse; remaining ends at 0.
- amount=2, hopper100_empty=1 → two out50 pulses, no out100, done once.
- amount=0 → no hopper pulses; done=1 in cycle 1; req_ready back in cycle 2.
- req_valid held high with a new amount=5 during an amount=1 refund → only 1 coin paid; second request accepted only once IDLE returns.
- reset asserted in the second PULSE cycle of an amount=4 refund → next cycle out100=0, busy=0, req_ready=1, no done.
- (CHANGE_TIMEOUT_EN) amount=1, hopper_ack never asserted → error=1 after 16 WAIT_ACK cycles and holds; reset clears it.

Source files
------------

// File: rtl/vm_pkg.sv
// Vending machine shared types and constants.
// CHANGE_TIMEOUT_EN adds the hopper-timeout ERROR state.
package vm_pkg;

  localparam int COIN_UNIT = 50;

  typedef enum logic [2:0] {
    CHG_IDLE,
    CHG_SELECT,
    CHG_PULSE,
    CHG_WAIT_ACK,
    CHG_GAP,
    CHG_DONE
`ifdef CHANGE_TIMEOUT_EN
    ,
    CHG_ERROR
`endif
  } chg_state_t;

  typedef enum logic {
    COIN_50,
    COIN_100
  } coin_t;

  function automatic logic [1:0] coin_units(
    input coin_t c
  );
    return (c == COIN_100) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/chg_timer.sv
// Loadable down-counter with zero flag.
// Shared by the pulse, gap and ack-timeout intervals.
module chg_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // load wins over decrement; count saturates at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return transmitter: pays out change one coin at a time.
// CHANGE_TIMEOUT_EN enables the sticky hopper-ack timeout.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W     = 4,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             hopper100_empty,
  input  logic             hopper_ack,
  output logic             out100,
  output logic             out50,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int PG_MAX =
    (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TMR_MAX =
    (TIMEOUT > PG_MAX) ? TIMEOUT : PG_MAX;
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  chg_state_t       state_q;
  chg_state_t       state_d;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] rem_d;
  coin_t            coin_q;
  coin_t            coin_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  chg_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // state, remaining amount and chosen coin
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CHG_IDLE;
      rem_q   <= '0;
      coin_q  <= COIN_50;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
    end
  end

  // next state and timer control
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    coin_d   = coin_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      CHG_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          state_d = (req_amount == '0)
                  ? CHG_DONE : CHG_SELECT;
        end
      end
      CHG_SELECT: begin
        coin_d = (rem_q >= AMT_W'(2)
                  && !hopper100_empty)
               ? COIN_100 : COIN_50;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PULSE_LEN - 1);
        state_d  = CHG_PULSE;
      end
      CHG_PULSE: begin
        if (tmr_zero) begin
`ifdef CHANGE_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT - 1);
`endif
          state_d = CHG_WAIT_ACK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHG_WAIT_ACK: begin
        if (hopper_ack) begin
          rem_d = rem_q
                - AMT_W'(coin_units(coin_q));
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_LEN - 1);
          state_d  = CHG_GAP;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (tmr_zero) begin
          state_d = CHG_ERROR;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      CHG_GAP: begin
        if (tmr_zero) begin
          state_d = (rem_q == '0)
                  ? CHG_DONE : CHG_SELECT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHG_DONE: begin
        state_d = CHG_IDLE;
      end
`ifdef CHANGE_TIMEOUT_EN
      CHG_ERROR: begin
        state_d = CHG_ERROR;
      end
`endif
      default: begin
        state_d = CHG_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == CHG_IDLE);
  assign busy      = (state_q != CHG_IDLE);
  assign done      = (state_q == CHG_DONE);
  assign out100    = (state_q == CHG_PULSE)
                  && (coin_q == COIN_100);
  assign out50     = (state_q == CHG_PULSE)
                  && (coin_q == COIN_50);

`ifdef CHANGE_TIMEOUT_EN
  assign error = (state_q == CHG_ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser.
// Hopper events are matched against a queue of expectations.
module tb_change_dispenser;

  localparam int AMT_W     = 4;
  localparam int PULSE_LEN = 2;
  localparam int GAP_LEN   = 2;
  localparam int TIMEOUT   = 16;

  localparam int K_DONE = 1;
  localparam int K_P50  = 50;
  localparam int K_P100 = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             hopper100_empty = 1'b0;
  logic             hopper_ack = 1'b0;
  logic             out100;
  logic             out50;
  logic             busy;
  logic             done;
  logic             error;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc_ctr = 0;
  int  base    = 0;
  int  ack_mode = 0;

  change_dispenser #(
    .AMT_W     (AMT_W),
    .PULSE_LEN (PULSE_LEN),
    .GAP_LEN   (GAP_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_amount      (req_amount),
    .req_ready       (req_ready),
    .hopper100_empty (hopper100_empty),
    .hopper_ack      (hopper_ack),
    .out100          (out100),
    .out50           (out50),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic push(int k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(int k, int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", k, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", k, e.kind);
    if (e.cyc >= 0) chk("ev_cyc", c, e.cyc);
  endtask

  task automatic send(int a);
    @(negedge clk);
    base       = cyc_ctr;
    req_valid  = 1'b1;
    req_amount = AMT_W'(a);
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(req_ready === 1'b1), 1);
  endtask

  // monitor: turns pulses and done into scoreboard events
  initial begin : mon
    int  kind;
    int  start;
    int  width;
    bit  in_p;
    logic any;
    in_p  = 1'b0;
    kind  = 0;
    start = 0;
    width = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_p = 1'b0;
        continue;
      end
      chk("onehot", int'(out100 & out50), 0);
      if (done === 1'b1) got(K_DONE, cyc_ctr - base);
      any = out100 | out50;
      if (!in_p && any === 1'b1) begin
        in_p  = 1'b1;
        kind  = (out100 === 1'b1) ? K_P100 : K_P50;
        start = cyc_ctr - base;
        width = 1;
      end else if (in_p && any === 1'b1) begin
        width++;
      end else if (in_p) begin
        in_p = 1'b0;
        chk("pulse_width", width, PULSE_LEN);
        got(kind, start);
      end
    end
  end

  // hopper model: 0 never acks, 1 acks a cycle after
  // each pulse, 2 holds ack high
  initial begin : hop
    bit prev;
    bit pend;
    bit cur;
    prev = 1'b0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      cur = (out100 === 1'b1) || (out50 === 1'b1);
      case (ack_mode)
        0: hopper_ack = 1'b0;
        2: hopper_ack = 1'b1;
        default: begin
          hopper_ack = pend;
          pend = prev && !cur;
        end
      endcase
      prev = cur;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(negedge clk);
    chk("rst_out100", int'(out100), 0);
    chk("rst_out50", int'(out50), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_rem", int'(dut.rem_q), 0);
    reset = 1'b0;

    // amount=1, ack already high: cycle-exact
    ack_mode = 2;
    push(K_P50, 2);
    push(K_DONE, 7);
    send(1);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      chk("t1_ready", int'(req_ready), int'(k == 8));
      chk("t1_busy", int'(busy), int'(k != 8));
    end

    // amount=3: one 100 then one 50
    ack_mode = 1;
    push(K_P100, 2);
    push(K_P50, 9);
    push(K_DONE, 15);
    send(3);
    wait_idle(60);
    chk("t2_rem", int'(dut.rem_q), 0);

    // amount=2, 100-hopper empty: two 50s
    hopper100_empty = 1'b1;
    push(K_P50, 2);
    push(K_P50, 9);
    push(K_DONE, 15);
    send(2);
    wait_idle(60);
    chk("t3_rem", int'(dut.rem_q), 0);
    hopper100_empty = 1'b0;

    // amount=0: done only
    push(K_DONE, 1);
    send(0);
    chk("t4_ready_c1", int'(req_ready), 0);
    @(negedge clk);
    chk("t4_ready_c2", int'(req_ready), 1);

    // request held high while busy is not queued
    ack_mode = 2;
    push(K_P50, 2);
    push(K_DONE, 7);
    push(K_P100, 10);
    push(K_P100, 16);
    push(K_P50, 22);
    push(K_DONE, 27);
    @(negedge clk);
    base       = cyc_ctr;
    req_valid  = 1'b1;
    req_amount = AMT_W'(1);
    @(negedge clk);
    req_amount = AMT_W'(5);
    repeat (7) @(negedge clk);
    chk("t5_ready_c8", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_busy_c9", int'(busy), 1);
    wait_idle(80);

    // reset in second PULSE cycle of amount=4
    ack_mode = 1;
    send(4);
    @(negedge clk);
    chk("t6_out100_c2", int'(out100), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_out100", int'(out100), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ready", int'(req_ready), 1);
    chk("t6_done", int'(done), 0);
    chk("t6_rem", int'(dut.rem_q), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // amount=1, hopper never acks
    ack_mode = 0;
    push(K_P50, 2);
    send(1);
`ifdef CHANGE_TIMEOUT_EN
    repeat (18) @(negedge clk);
    chk("t7_err_c19", int'(error), 0);
    @(negedge clk);
    chk("t7_err_c20", int'(error), 1);
    chk("t7_busy", int'(busy), 1);
    chk("t7_ready", int'(req_ready), 0);
    repeat (5) @(negedge clk);
    chk("t7_err_hold", int'(error), 1);
    chk("t7_out50", int'(out50), 0);
`else
    repeat (30) @(negedge clk);
    chk("t7_err", int'(error), 0);
    chk("t7_busy", int'(busy), 1);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("t7_err_rst", int'(error), 0);
    chk("t7_ready_rst", int'(req_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    chk("leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
